sd_host_data_fifo: RTL and testbench

//  Data buffer behind the Wishbone slave's FIFO port (adr 17 write, adr 18 read); downstream of the slave.
//  TX path: stores 128-bit words written by the slave and serializes them to a 32-bit valid/ready stream for the SD data PHY.
//  RX path: packs 32-bit PHY words into 128-bit words and holds them for slave reads.

---
 rtl/sd_host_data_fifo_if.sv | 52 +++++
 rtl/sd_host_data_fifo.sv | 179 +++++++++++++++++
 tb/tb_sd_host_data_fifo.sv | 515 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_host_data_fifo_if.sv
// sd_host_data_fifo_if
//   Bundles every data, handshake and status signal of sd_host_data_fifo.
//   slave  : modport used by the FIFO block itself.
//   master : modport for whatever drives it (Wishbone slave + SD data PHY side).
//   Signals:
//     fifo_write_en / wr_data_i     TX push from the Wishbone slave (128 bit)
//     fifo_read_en  / rd_data_o     RX pop, show-ahead head word (128 bit)
//     tx_data_o / tx_valid_o / tx_ready_i   32-bit TX lane stream to the PHY
//     rx_data_i / rx_valid_i / rx_ready_o   32-bit RX lane stream from the PHY
//     flush_i, clr_err_i            one-cycle clear of data paths / sticky errors
//     tx_count_o, rx_count_o        FIFO occupancy (AW+1 bits)
//     tx/rx full/empty, ovf_err_o, unf_err_o   status and sticky errors
interface sd_host_data_fifo_if #(
  parameter int AW = 3
);
  logic          fifo_write_en;
  logic [127:0]  wr_data_i;
  logic          fifo_read_en;
  logic [127:0]  rd_data_o;
  logic [31:0]   tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i;
  logic [31:0]   rx_data_i;
  logic          rx_valid_i;
  logic          rx_ready_o;
  logic          flush_i;
  logic          clr_err_i;
  logic [AW:0]   tx_count_o;
  logic [AW:0]   rx_count_o;
  logic          tx_full_o;
  logic          tx_empty_o;
  logic          rx_full_o;
  logic          rx_empty_o;
  logic          ovf_err_o;
  logic          unf_err_o;

  modport slave (
    input  fifo_write_en, wr_data_i, fifo_read_en, tx_ready_i,
           rx_data_i, rx_valid_i, flush_i, clr_err_i,
    output rd_data_o, tx_data_o, tx_valid_o, rx_ready_o, tx_count_o,
           rx_count_o, tx_full_o, tx_empty_o, rx_full_o, rx_empty_o,
           ovf_err_o, unf_err_o
  );

  modport master (
    output fifo_write_en, wr_data_i, fifo_read_en, tx_ready_i,
           rx_data_i, rx_valid_i, flush_i, clr_err_i,
    input  rd_data_o, tx_data_o, tx_valid_o, rx_ready_o, tx_count_o,
           rx_count_o, tx_full_o, tx_empty_o, rx_full_o, rx_empty_o,
           ovf_err_o, unf_err_o
  );
endinterface

// File: rtl/sd_host_data_fifo.sv
// sd_host_data_fifo
//   Data buffer between the Wishbone slave FIFO port and the SD data PHY.
//   TX: 128-bit words are queued and serialized onto a 32-bit valid/ready
//       lane, lane 0 ([31:0]) first, with no bubble between queued words.
//   RX: 32-bit PHY lanes are packed (lane k -> bits [32k+:32]) into 128-bit
//       words and queued for show-ahead reads by the slave.
//   Ports:
//     clock  rising-edge clock
//     reset  synchronous, active-high; clears pointers, counts, serializer,
//            packer and sticky errors
//     bus    sd_host_data_fifo_if.slave, all data/handshake/status signals
module sd_host_data_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  sd_host_data_fifo_if.slave    bus
);

  typedef enum logic {S_IDLE, S_BUSY} ser_state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [127:0]  tx_mem [DEPTH];
  logic [127:0]  rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]   tx_count, rx_count;

  ser_state_t    state;
  logic [1:0]    lane;
  logic [95:0]   tx_hold;   // lanes not yet presented, next lane in [31:0]
  logic [31:0]   tx_data;
  logic          tx_valid;

  logic [1:0]    rx_lane;
  logic [95:0]   rx_pack;   // accepted lanes shift in from the top
  logic          ovf_err, unf_err;

  logic tx_full, tx_fifo_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_hs, rx_accept, rx_push, rx_pop;
  logic ovf_set, unf_set;
  logic [127:0] tx_head;

  assign tx_full       = (tx_count == FULL_CNT);
  assign tx_fifo_empty = (tx_count == '0);
  assign rx_full       = (rx_count == FULL_CNT);
  assign rx_empty      = (rx_count == '0);
  assign tx_head       = tx_mem[tx_rd_ptr];

  // Fullness is the registered count, so a serializer pop in the same cycle
  // never makes room for a write; likewise an RX pop never raises rx_ready.
  assign tx_push   = bus.fifo_write_en && !tx_full && !bus.flush_i;
  assign tx_hs     = tx_valid && bus.tx_ready_i;
  assign tx_pop    = !tx_fifo_empty && !bus.flush_i &&
                     ((state == S_IDLE) || (tx_hs && lane == 2'd3));
  assign rx_accept = bus.rx_valid_i && !rx_full && !bus.flush_i;
  assign rx_push   = rx_accept && (rx_lane == 2'd3);
  assign rx_pop    = bus.fifo_read_en && !rx_empty && !bus.flush_i;
  assign ovf_set   = bus.fifo_write_en && tx_full && !bus.flush_i;
  assign unf_set   = bus.fifo_read_en && rx_empty && !bus.flush_i;

  // NOTE: storage arrays carry no reset; valid contents are defined by the
  // pointers and counts, so clearing them would only cost flops.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.wr_data_i;
    if (rx_push) rx_mem[rx_wr_ptr] <= {bus.rx_data_i, rx_pack};
  end

  // NOTE: all state uses non-blocking assignments so every block samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clock) begin
    if (reset || bus.flush_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // Serializer: tx_valid/tx_data are registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset || bus.flush_i) begin
      state    <= S_IDLE;
      lane     <= '0;
      tx_hold  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_pop) begin
            state    <= S_BUSY;
            lane     <= '0;
            tx_hold  <= tx_head[127:32];
            tx_data  <= tx_head[31:0];
            tx_valid <= 1'b1;
          end
        end
        S_BUSY: begin
          if (tx_hs) begin
            if (lane != 2'd3) begin
              lane    <= lane + 2'd1;
              tx_data <= tx_hold[31:0];
              tx_hold <= {32'd0, tx_hold[95:32]};
            end else if (tx_pop) begin
              // Next word follows lane 3 directly, no idle cycle.
              lane    <= '0;
              tx_hold <= tx_head[127:32];
              tx_data <= tx_head[31:0];
            end else begin
              state    <= S_IDLE;
              tx_data  <= '0;
              tx_valid <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || bus.flush_i) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      rx_lane   <= '0;
      rx_pack   <= '0;
    end else begin
      if (rx_accept) begin
        rx_lane <= rx_lane + 2'd1;
        rx_pack <= {bus.rx_data_i, rx_pack[95:32]};
      end
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Sticky errors: a new error wins over a same-cycle clear; flush leaves
  // them untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (!bus.flush_i) begin
      if (ovf_set)            ovf_err <= 1'b1;
      else if (bus.clr_err_i) ovf_err <= 1'b0;
      if (unf_set)            unf_err <= 1'b1;
      else if (bus.clr_err_i) unf_err <= 1'b0;
    end
  end

  assign bus.rd_data_o  = rx_empty ? '0 : rx_mem[rx_rd_ptr];
  assign bus.tx_data_o  = tx_data;
  assign bus.tx_valid_o = tx_valid;
  assign bus.rx_ready_o = !rx_full;
  assign bus.tx_count_o = tx_count;
  assign bus.rx_count_o = rx_count;
  assign bus.tx_full_o  = tx_full;
  assign bus.tx_empty_o = tx_fifo_empty && (state == S_IDLE);
  assign bus.rx_full_o  = rx_full;
  assign bus.rx_empty_o = rx_empty;
  assign bus.ovf_err_o  = ovf_err;
  assign bus.unf_err_o  = unf_err;

endmodule

// File: tb/tb_sd_host_data_fifo.sv
// tb_sd_host_data_fifo
//   Directed scenarios for the serializer, packer, full/empty boundaries,
//   flush and reset, followed by randomized traffic compared every cycle
//   against a queue-based reference model.
module tb_sd_host_data_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  sd_host_data_fifo_if #(.AW(AW)) bus ();

  sd_host_data_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state: plain queues of words and lanes.
  logic [127:0] m_txq[$];
  logic [127:0] m_rxq[$];
  logic [31:0]  m_part[$];
  logic [127:0] m_word;
  bit           m_busy;
  int           m_lane;
  bit           m_ovf, m_unf;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] dut_flags();
    return {bus.tx_valid_o, bus.tx_full_o, bus.tx_empty_o, bus.rx_full_o,
            bus.rx_empty_o, bus.rx_ready_o, bus.ovf_err_o, bus.unf_err_o};
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.fifo_write_en = 1'b0;
    bus.wr_data_i     = '0;
    bus.fifo_read_en  = 1'b0;
    bus.tx_ready_i    = 1'b0;
    bus.rx_data_i     = '0;
    bus.rx_valid_i    = 1'b0;
    bus.flush_i       = 1'b0;
    bus.clr_err_i     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic model_clear();
    m_txq.delete();
    m_rxq.delete();
    m_part.delete();
    m_busy = 1'b0;
    m_lane = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit tx_full_now, rx_full_now, push, accept, pop;
    if (reset) begin
      model_clear();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (bus.flush_i) begin
      model_clear();
    end else begin
      tx_full_now = (m_txq.size() == DEPTH);
      push = bus.fifo_write_en && !tx_full_now;
      if (!m_busy) begin
        if (m_txq.size() > 0) begin
          m_word = m_txq.pop_front();
          m_busy = 1'b1;
          m_lane = 0;
        end
      end else if (bus.tx_ready_i) begin
        if (m_lane == 3) begin
          if (m_txq.size() > 0) begin
            m_word = m_txq.pop_front();
            m_lane = 0;
          end else begin
            m_busy = 1'b0;
          end
        end else begin
          m_lane++;
        end
      end
      if (push) m_txq.push_back(bus.wr_data_i);

      rx_full_now = (m_rxq.size() == DEPTH);
      accept = bus.rx_valid_i && !rx_full_now;
      pop    = bus.fifo_read_en && (m_rxq.size() > 0);
      if (bus.fifo_read_en && m_rxq.size() == 0) m_unf = 1'b1;
      else if (bus.clr_err_i)                    m_unf = 1'b0;
      if (bus.fifo_write_en && tx_full_now)      m_ovf = 1'b1;
      else if (bus.clr_err_i)                    m_ovf = 1'b0;
      if (pop) void'(m_rxq.pop_front());
      if (accept) begin
        m_part.push_back(bus.rx_data_i);
        if (m_part.size() == 4) begin
          m_rxq.push_back({m_part[3], m_part[2], m_part[1], m_part[0]});
          m_part.delete();
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.fifo_write_en = 1'b1;
    bus.wr_data_i     = rand128();
    bus.rx_valid_i    = 1'b1;
    bus.rx_data_i     = $urandom;
    bus.fifo_read_en  = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dut_flags() !== 8'b0010_1100) begin
        errors++;
        $display("FAIL reset_flags[%0d] got %b exp %b", i, dut_flags(), 8'b0010_1100);
      end
      checks++;
      if ({bus.tx_count_o, bus.rx_count_o, bus.tx_data_o, bus.rd_data_o} !== '0) begin
        errors++;
        $display("FAIL reset_data[%0d] tx_count %0d rx_count %0d tx_data %h rd_data %h exp all 0",
                 i, bus.tx_count_o, bus.rx_count_o, bus.tx_data_o, bus.rd_data_o);
      end
      tick();
    end
  endtask

  task automatic test_tx_serialize();
    logic [31:0] lanes [4];
    lanes = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_reset();
    bus.tx_ready_i    = 1'b1;
    bus.wr_data_i     = {lanes[3], lanes[2], lanes[1], lanes[0]};
    bus.fifo_write_en = 1'b1;
    tick();
    bus.fifo_write_en = 1'b0;
    checks++;
    if ({bus.tx_count_o, bus.tx_valid_o} !== {4'd1, 1'b0}) begin
      errors++;
      $display("FAIL ser_queued tx_count %0d tx_valid %b exp 1 0", bus.tx_count_o, bus.tx_valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.tx_valid_o, bus.tx_data_o} !== {1'b1, lanes[i]}) begin
        errors++;
        $display("FAIL ser_lane%0d valid %b data %h exp 1 %h", i, bus.tx_valid_o, bus.tx_data_o, lanes[i]);
      end
    end
    tick();
    checks++;
    if ({bus.tx_valid_o, bus.tx_empty_o} !== 2'b01) begin
      errors++;
      $display("FAIL ser_done valid %b tx_empty %b exp 0 1", bus.tx_valid_o, bus.tx_empty_o);
    end
  endtask

  task automatic test_tx_overflow();
    logic [127:0] words [9];
    int got;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      words[i] = rand128();
      bus.wr_data_i     = words[i];
      bus.fifo_write_en = 1'b1;
      tick();
    end
    bus.fifo_write_en = 1'b0;
    checks++;
    if ({bus.tx_count_o, bus.tx_full_o, bus.ovf_err_o, bus.tx_valid_o, bus.tx_data_o} !==
        {4'd8, 1'b1, 1'b0, 1'b1, words[0][31:0]}) begin
      errors++;
      $display("FAIL ovf_fill count %0d full %b ovf %b valid %b data %h exp 8 1 0 1 %h",
               bus.tx_count_o, bus.tx_full_o, bus.ovf_err_o, bus.tx_valid_o,
               bus.tx_data_o, words[0][31:0]);
    end
    bus.wr_data_i     = rand128();
    bus.fifo_write_en = 1'b1;
    tick();
    bus.fifo_write_en = 1'b0;
    checks++;
    if ({bus.ovf_err_o, bus.tx_count_o, bus.tx_full_o} !== {1'b1, 4'd8, 1'b1}) begin
      errors++;
      $display("FAIL ovf_set ovf %b count %0d full %b exp 1 8 1", bus.ovf_err_o, bus.tx_count_o, bus.tx_full_o);
    end
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    checks++;
    if (bus.ovf_err_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear ovf %b exp 0", bus.ovf_err_o);
    end
    bus.tx_ready_i = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 36; cyc++) begin
      if (bus.tx_valid_o) begin
        checks++;
        if (bus.tx_data_o !== words[got/4][32*(got%4) +: 32]) begin
          errors++;
          $display("FAIL ovf_drain lane %0d got %h exp %h", got, bus.tx_data_o, words[got/4][32*(got%4) +: 32]);
        end
        got++;
      end
      tick();
    end
    checks++;
    if (got != 36 || {bus.tx_valid_o, bus.tx_empty_o} !== 2'b01) begin
      errors++;
      $display("FAIL ovf_drain_end lanes %0d valid %b empty %b exp 36 0 1", got, bus.tx_valid_o, bus.tx_empty_o);
    end
  endtask

  task automatic test_rx_pack();
    logic [31:0] r [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      r[i] = $urandom;
      if (i == 3) begin
        checks++;
        if ({bus.rx_count_o, bus.rx_empty_o} !== {4'd0, 1'b1}) begin
          errors++;
          $display("FAIL pack_partial count %0d empty %b exp 0 1", bus.rx_count_o, bus.rx_empty_o);
        end
      end
      bus.rx_data_i  = r[i];
      bus.rx_valid_i = 1'b1;
      tick();
    end
    bus.rx_valid_i = 1'b0;
    checks++;
    if ({bus.rx_count_o, bus.rx_empty_o, bus.rd_data_o} !== {4'd1, 1'b0, r[3], r[2], r[1], r[0]}) begin
      errors++;
      $display("FAIL pack_word count %0d empty %b data %h exp 1 0 %h", bus.rx_count_o,
               bus.rx_empty_o, bus.rd_data_o, {r[3], r[2], r[1], r[0]});
    end
    bus.fifo_read_en = 1'b1;
    tick();
    bus.fifo_read_en = 1'b0;
    checks++;
    if ({bus.rx_empty_o, bus.rx_count_o, bus.rd_data_o, bus.unf_err_o} !== {1'b1, 4'd0, 128'd0, 1'b0}) begin
      errors++;
      $display("FAIL pack_pop empty %b count %0d data %h unf %b exp 1 0 0 0",
               bus.rx_empty_o, bus.rx_count_o, bus.rd_data_o, bus.unf_err_o);
    end
  endtask

  task automatic test_rx_full_underflow();
    logic [127:0] q[$];
    logic [127:0] w;
    do_reset();
    for (int n = 0; n < 9; n++) begin
      w = rand128();
      for (int k = 0; k < 4; k++) begin
        bus.rx_data_i  = w[32*k +: 32];
        bus.rx_valid_i = 1'b1;
        tick();
      end
      q.push_back(w);
      bus.rx_valid_i = 1'b0;
      if (n == 7) begin
        checks++;
        if ({bus.rx_count_o, bus.rx_full_o, bus.rx_ready_o} !== {4'd8, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL rx_full count %0d full %b ready %b exp 8 1 0", bus.rx_count_o, bus.rx_full_o, bus.rx_ready_o);
        end
      end
    end
    // Ninth word was offered while full and must have been refused whole.
    void'(q.pop_back());
    checks++;
    if (bus.rx_count_o !== 4'd8) begin
      errors++;
      $display("FAIL rx_refuse count %0d exp 8", bus.rx_count_o);
    end
    bus.fifo_read_en = 1'b1;
    checks++;
    if ({bus.rd_data_o, bus.rx_ready_o} !== {q[0], 1'b0}) begin
      errors++;
      $display("FAIL rx_pop_full data %h ready %b exp %h 0", bus.rd_data_o, bus.rx_ready_o, q[0]);
    end
    tick();
    void'(q.pop_front());
    bus.fifo_read_en = 1'b0;
    checks++;
    if ({bus.rx_ready_o, bus.rx_count_o} !== {1'b1, 4'd7}) begin
      errors++;
      $display("FAIL rx_ready_after_pop ready %b count %0d exp 1 7", bus.rx_ready_o, bus.rx_count_o);
    end
    for (int i = 0; i < 7; i++) begin
      bus.fifo_read_en = 1'b1;
      checks++;
      if (bus.rd_data_o !== q[0]) begin
        errors++;
        $display("FAIL rx_drain[%0d] got %h exp %h", i, bus.rd_data_o, q[0]);
      end
      void'(q.pop_front());
      tick();
    end
    bus.fifo_read_en = 1'b0;
    checks++;
    if ({bus.rx_empty_o, bus.unf_err_o} !== 2'b10) begin
      errors++;
      $display("FAIL rx_drained empty %b unf %b exp 1 0", bus.rx_empty_o, bus.unf_err_o);
    end
    // Empty read with a same-cycle clear: the error must still be set.
    bus.fifo_read_en = 1'b1;
    bus.clr_err_i    = 1'b1;
    tick();
    bus.fifo_read_en = 1'b0;
    bus.clr_err_i    = 1'b0;
    checks++;
    if ({bus.unf_err_o, bus.rd_data_o, bus.rx_count_o} !== {1'b1, 128'd0, 4'd0}) begin
      errors++;
      $display("FAIL unf_set unf %b data %h count %0d exp 1 0 0", bus.unf_err_o, bus.rd_data_o, bus.rx_count_o);
    end
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    checks++;
    if (bus.unf_err_o !== 1'b0) begin
      errors++;
      $display("FAIL unf_clear unf %b exp 0", bus.unf_err_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] w0, w1, exp_w;
    int idx, stall;
    bit seen, rdy;
    do_reset();
    w0 = rand128();
    w1 = rand128();
    bus.fifo_write_en = 1'b1;
    bus.wr_data_i     = w0;
    tick();
    bus.wr_data_i     = w1;
    tick();
    bus.fifo_write_en = 1'b0;
    idx = 0; stall = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 40 && idx < 8; cyc++) begin
      exp_w = (idx < 4) ? w0 : w1;
      if (bus.tx_valid_o) seen = 1'b1;
      if (seen) begin
        checks++;
        if ({bus.tx_valid_o, bus.tx_data_o} !== {1'b1, exp_w[32*(idx%4) +: 32]}) begin
          errors++;
          $display("FAIL b2b_lane%0d valid %b data %h exp 1 %h", idx, bus.tx_valid_o,
                   bus.tx_data_o, exp_w[32*(idx%4) +: 32]);
        end
      end
      rdy = !(idx == 1 && stall < 3);
      if (!rdy) stall++;
      bus.tx_ready_i = rdy;
      if (rdy && bus.tx_valid_o) idx++;
      tick();
    end
    bus.tx_ready_i = 1'b0;
    checks++;
    if (idx != 8 || bus.tx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end lanes %0d valid %b exp 8 0", idx, bus.tx_valid_o);
    end
  endtask

  task automatic test_flush(input bit use_reset);
    logic [127:0] w;
    logic [31:0]  y [4];
    do_reset();
    w = rand128();
    bus.wr_data_i     = w;
    bus.fifo_write_en = 1'b1;
    bus.rx_data_i     = $urandom;
    bus.rx_valid_i    = 1'b1;
    bus.fifo_read_en  = 1'b1;   // empty read: sets unf_err
    tick();
    bus.fifo_write_en = 1'b0;
    bus.fifo_read_en  = 1'b0;
    bus.rx_data_i     = $urandom;
    tick();
    bus.rx_valid_i = 1'b0;
    bus.tx_ready_i = 1'b1;
    tick();
    checks++;
    if ({bus.tx_valid_o, bus.tx_data_o, bus.unf_err_o} !== {1'b1, w[63:32], 1'b1}) begin
      errors++;
      $display("FAIL flush%0d_pre valid %b data %h unf %b exp 1 %h 1", use_reset,
               bus.tx_valid_o, bus.tx_data_o, bus.unf_err_o, w[63:32]);
    end
    if (use_reset) reset = 1'b1;
    else           bus.flush_i = 1'b1;
    bus.fifo_write_en = 1'b1;
    bus.wr_data_i     = rand128();
    tick();
    reset = 1'b0;
    idle_inputs();
    bus.tx_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.tx_valid_o, bus.tx_count_o, bus.rx_count_o, bus.tx_empty_o, bus.rx_empty_o, bus.unf_err_o} !==
          {1'b0, 4'd0, 4'd0, 1'b1, 1'b1, !use_reset}) begin
        errors++;
        $display("FAIL flush%0d_after[%0d] valid %b txc %0d rxc %0d txe %b rxe %b unf %b exp 0 0 0 1 1 %b",
                 use_reset, i, bus.tx_valid_o, bus.tx_count_o, bus.rx_count_o,
                 bus.tx_empty_o, bus.rx_empty_o, bus.unf_err_o, !use_reset);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      y[k] = $urandom;
      bus.rx_data_i  = y[k];
      bus.rx_valid_i = 1'b1;
      tick();
    end
    bus.rx_valid_i = 1'b0;
    checks++;
    if ({bus.rx_count_o, bus.rd_data_o} !== {4'd1, y[3], y[2], y[1], y[0]}) begin
      errors++;
      $display("FAIL flush%0d_clean count %0d data %h exp 1 %h", use_reset,
               bus.rx_count_o, bus.rd_data_o, {y[3], y[2], y[1], y[0]});
    end
  endtask

  task automatic test_random();
    logic [7:0]   exp_flags;
    logic [127:0] exp_rd;
    int ph;
    do_reset();
    model_clear();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_flags = {m_busy, m_txq.size() == DEPTH, m_txq.size() == 0 && !m_busy,
                   m_rxq.size() == DEPTH, m_rxq.size() == 0, m_rxq.size() < DEPTH, m_ovf, m_unf};
      exp_rd = (m_rxq.size() > 0) ? m_rxq[0] : '0;
      checks++;
      if ({dut_flags(), bus.tx_count_o, bus.rx_count_o} !==
          {exp_flags, (AW+1)'(m_txq.size()), (AW+1)'(m_rxq.size())}) begin
        errors++;
        $display("FAIL rnd_status cyc %0d flags %b txc %0d rxc %0d exp %b %0d %0d", cyc,
                 dut_flags(), bus.tx_count_o, bus.rx_count_o, exp_flags, m_txq.size(), m_rxq.size());
      end
      checks++;
      if (bus.rd_data_o !== exp_rd) begin
        errors++;
        $display("FAIL rnd_rd_data cyc %0d got %h exp %h", cyc, bus.rd_data_o, exp_rd);
      end
      if (m_busy) begin
        checks++;
        if (bus.tx_data_o !== m_word[32*m_lane +: 32]) begin
          errors++;
          $display("FAIL rnd_tx_data cyc %0d got %h exp %h", cyc, bus.tx_data_o, m_word[32*m_lane +: 32]);
        end
      end
      ph = (cyc / 300) % 4;
      bus.fifo_write_en = $urandom_range(99) < ((ph == 1) ? 80 : (ph == 3) ? 15 : 40);
      bus.wr_data_i     = rand128();
      bus.tx_ready_i    = $urandom_range(99) < ((ph == 1) ? 15 : (ph == 3) ? 90 : 60);
      bus.rx_valid_i    = $urandom_range(99) < ((ph == 2) ? 95 : 50);
      bus.rx_data_i     = $urandom;
      bus.fifo_read_en  = $urandom_range(99) < ((ph == 2) ? 5 : (ph == 3) ? 80 : 20);
      bus.flush_i       = $urandom_range(149) == 0;
      bus.clr_err_i     = $urandom_range(19) == 0;
      reset             = $urandom_range(799) == 0;
      model_step();
      tick();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    @(negedge clock);
    test_reset();
    test_tx_serialize();
    test_tx_overflow();
    test_rx_pack();
    test_rx_full_underflow();
    test_back_to_back();
    test_flush(1'b0);
    test_flush(1'b1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
